// File: rtl/irq_sequencer.sv
// irq_sequencer: turns a set of level interrupt lines into one CPU interrupt
// with a claim/complete handshake. Rising edges are latched into a pending
// register, masked by enableMask, and one winner is presented to the core
// until the core claims it; further signalling is blocked until complete.
//
// Optional build macro: IRQ_ROUND_ROBIN_EN
//   undefined : fixed priority, lowest eligible index wins
//   defined   : search starts at rrBase (index after the last claimed ID)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   extIrq      level-high interrupt sources, synchronous to clk
//   enableMask  per-source enable (1 = may signal)
//   claim       CPU accepts the presented interrupt (1-cycle pulse)
//   complete    CPU finished the handler (1-cycle pulse)
//   interrupt   registered interrupt request to the CPU
//   irqId       registered ID of the presented / claimed source
//   busy        registered, a claimed interrupt is in service
module irq_sequencer #(
    parameter int unsigned EXT_IRQ_COUNT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [EXT_IRQ_COUNT-1:0] extIrq,
    input  logic [EXT_IRQ_COUNT-1:0] enableMask,
    input  logic                     claim,
    input  logic                     complete,
    output logic                     interrupt,
    output logic [((EXT_IRQ_COUNT > 1) ? $clog2(EXT_IRQ_COUNT) : 1)-1:0] irqId,
    output logic                     busy
);

    localparam int unsigned ID_W = (EXT_IRQ_COUNT > 1) ? $clog2(EXT_IRQ_COUNT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SIGNAL  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t                   r_state;
    logic [EXT_IRQ_COUNT-1:0] r_prev;
    logic [EXT_IRQ_COUNT-1:0] r_pending;
    logic                     r_interrupt;
    logic [ID_W-1:0]          r_irq_id;
    logic                     r_busy;

    logic [EXT_IRQ_COUNT-1:0] w_rise;
    logic [EXT_IRQ_COUNT-1:0] w_elig;
    logic [EXT_IRQ_COUNT-1:0] w_clear;
    logic [ID_W-1:0]          w_winner;
    logic [ID_W-1:0]          w_next_base;

    assign w_rise = extIrq & ~r_prev;
    assign w_elig = r_pending & enableMask;

    // Index following the presented ID, wrapping at EXT_IRQ_COUNT
    assign w_next_base = (32'(r_irq_id) == EXT_IRQ_COUNT - 1) ? '0 : r_irq_id + ID_W'(1);

    // Pending bit to drop: the presented source, only on an accepted claim
    always_comb begin
        w_clear = '0;
        if (r_state == ST_SIGNAL && claim) begin
            w_clear[r_irq_id] = 1'b1;
        end
    end

`ifdef IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0] r_rr_base;
    logic [ID_W-1:0] w_hi_idx;
    logic [ID_W-1:0] w_lo_idx;
    logic            w_hi_found;

    // Two scans: lowest eligible index at/above rrBase, else lowest overall (wrap)
    always_comb begin
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_hi_found = 1'b0;
        for (int i = int'(EXT_IRQ_COUNT) - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_lo_idx = ID_W'(i);
                if (i >= int'(r_rr_base)) begin
                    w_hi_idx   = ID_W'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    end
`else
    // Fixed priority: lowest eligible index wins
    always_comb begin
        w_winner = '0;
        for (int i = int'(EXT_IRQ_COUNT) - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_winner = ID_W'(i);
            end
        end
    end
`endif

    // Edge capture, pending register and claim/complete state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_prev      <= '0;
            r_pending   <= '0;
            r_interrupt <= 1'b0;
            r_irq_id    <= '0;
            r_busy      <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
            r_rr_base   <= '0;
`endif
        end else begin
            r_prev    <= extIrq;
            // A rise in the claim cycle survives the clear
            r_pending <= (r_pending & ~w_clear) | w_rise;

            case (r_state)
                ST_IDLE: begin
                    if (|w_elig) begin
                        r_state     <= ST_SIGNAL;
                        r_interrupt <= 1'b1;
                        r_irq_id    <= w_winner;
                    end
                end
                ST_SIGNAL: begin
                    if (claim) begin
                        r_state     <= ST_SERVICE;
                        r_interrupt <= 1'b0;
                        r_busy      <= 1'b1;
`ifdef IRQ_ROUND_ROBIN_EN
                        r_rr_base   <= w_next_base;
`endif
                    end else if (!(|w_elig)) begin
                        r_state     <= ST_IDLE;
                        r_interrupt <= 1'b0;
                    end else begin
                        // Later, higher-priority arrivals may replace the presented ID
                        r_irq_id    <= w_winner;
                    end
                end
                ST_SERVICE: begin
                    if (complete) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_interrupt <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

`ifndef IRQ_ROUND_ROBIN_EN
    // Only the round-robin build consumes the next search base
    logic w_unused;
    assign w_unused = ^w_next_base;
`endif

    assign interrupt = r_interrupt;
    assign irqId     = r_irq_id;
    assign busy      = r_busy;

endmodule
